// File: rtl/fir_moving_avg_mc.sv
// fir_moving_avg_mc: multi-channel moving-average FIR with optional decimation
module fir_moving_avg_mc #(
  parameter real TCQ        = 0.1,
  parameter int  DATA_WIDTH = 16,
  parameter int  CH_NUM     = 4,
  parameter int  MAX_TAPS   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         laser_start_i,
  input  logic [7:0]                   win_len_i,
  input  logic                         decim_en_i,
  input  logic                         laser_vld_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0] laser_data_i,
  output logic                         lp_laser_vld_o,
  output logic [CH_NUM*DATA_WIDTH-1:0] lp_laser_data_o,
  output logic                         win_full_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(MAX_TAPS);
  localparam int SW = DW + AW;
  if (MAX_TAPS < 2 || MAX_TAPS > 256 || (MAX_TAPS & (MAX_TAPS - 1)) != 0 || TCQ < 0.0) begin : g_bad_param
    $error("fir_moving_avg_mc: MAX_TAPS must be a power of two in 2..256 and TCQ non-negative");
  end
  logic          start_q, armed_q, dec_q, full_q, v1_q, v2_q, v3_q, vld_q;
  logic [8:0]    w_q, fill_q, phase_q;
  logic [AW-1:0] ptr_q;
  logic [SW-1:0] sum_q [CH_NUM];
  logic [DW-1:0] q2_q  [CH_NUM];
  logic [DW-1:0] q3_q  [CH_NUM];
  logic [DW-1:0] mem   [CH_NUM][MAX_TAPS];
  logic [CH_NUM*DW-1:0] out_q;
  logic          rise, acc, dec_eff, last, emit, hist, full_d;
  logic [8:0]    w_new, w_eff, fill_d, phase_d;
  logic [AW-1:0] rd_idx, ptr_d;
  logic [SW-1:0] sum_d [CH_NUM];
  logic [DW-1:0] q2_d  [CH_NUM];
  always_comb begin
    rise    = laser_start_i & ~start_q;
    w_new   = ({1'b0, win_len_i} >= 9'(MAX_TAPS)) ? 9'(MAX_TAPS) : {1'b0, win_len_i} + 9'd1;
    w_eff   = rise ? w_new : w_q;
    dec_eff = rise ? decim_en_i : dec_q;
    acc     = laser_vld_i & laser_start_i & (armed_q | rise);
    last    = phase_q == w_eff - 9'd1;
    emit    = acc & (~dec_eff | last);
    // zero-filled history until W samples are in; index wraps naturally at MAX_TAPS
    hist    = fill_q >= w_eff;
    rd_idx  = ptr_q - w_eff[AW-1:0];
    fill_d  = (acc & ~hist) ? fill_q + 9'd1 : fill_q;
    phase_d = acc ? (last ? 9'd0 : phase_q + 9'd1) : phase_q;
    ptr_d   = acc ? ptr_q + 1'b1 : ptr_q;
    full_d  = fill_d >= w_eff;
    for (int c = 0; c < CH_NUM; c++) begin
      sum_d[c] = acc ? sum_q[c] + SW'(laser_data_i[c*DW +: DW]) - (hist ? SW'(mem[c][rd_idx]) : '0) : sum_q[c];
      q2_d[c]  = DW'(sum_q[c] / SW'(w_q));
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc)
      for (int c = 0; c < CH_NUM; c++) mem[c][ptr_q] <= laser_data_i[c*DW +: DW];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q <= 1'b1;
      armed_q <= 1'b0;
      dec_q   <= 1'b0;
      w_q     <= 9'd1;
      fill_q  <= '0;
      phase_q <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        sum_q[c] <= '0;
        q2_q[c]  <= '0;
        q3_q[c]  <= '0;
      end
    end else begin
      start_q <= laser_start_i;
      vld_q   <= v3_q & laser_start_i;
      if (v3_q & laser_start_i)
        for (int c = 0; c < CH_NUM; c++) out_q[c*DW +: DW] <= q3_q[c];
      q2_q <= q2_d;
      q3_q <= q2_q;
      if (!laser_start_i) begin
        armed_q <= 1'b0;
        fill_q  <= '0;
        phase_q <= '0;
        ptr_q   <= '0;
        full_q  <= 1'b0;
        v1_q    <= 1'b0;
        v2_q    <= 1'b0;
        v3_q    <= 1'b0;
        for (int c = 0; c < CH_NUM; c++) sum_q[c] <= '0;
      end else begin
        armed_q <= armed_q | rise;
        w_q     <= w_eff;
        dec_q   <= dec_eff;
        fill_q  <= fill_d;
        phase_q <= phase_d;
        ptr_q   <= ptr_d;
        full_q  <= full_d;
        v1_q    <= emit;
        v2_q    <= v1_q;
        v3_q    <= v2_q;
        sum_q   <= sum_d;
      end
    end
  end
  assign lp_laser_vld_o  = vld_q;
  assign lp_laser_data_o = out_q;
  assign win_full_o      = full_q;
endmodule

// File: tb/tb_fir_moving_avg_mc.sv
// tb_fir_moving_avg_mc: table vectors plus scoreboarded corner-case sequences
module tb_fir_moving_avg_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        laser_start = 1'b0;
  logic [7:0]  win_len = '0;
  logic        decim = 1'b0;
  logic        laser_vld = 1'b0;
  logic [63:0] laser_data = '0;
  logic        lp_vld, win_full;
  logic [63:0] lp_data;

  fir_moving_avg_mc #(.DATA_WIDTH(16), .CH_NUM(4), .MAX_TAPS(32)) dut (
    .clk_i(clk), .rst_i(rst), .laser_start_i(laser_start), .win_len_i(win_len),
    .decim_en_i(decim), .laser_vld_i(laser_vld), .laser_data_i(laser_data),
    .lp_laser_vld_o(lp_vld), .lp_laser_data_o(lp_data), .win_full_o(win_full)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] d; } exp_t;
  typedef struct { logic [63:0] d; logic [63:0] e; bit full; } vec_t;
  exp_t        sb[$];
  logic [63:0] hist[$];
  logic [63:0] last_d;
  int          cyc = 0, n_vec = 0, n_bad = 0, w_m = 1, ph_m = 0;
  bit          dec_m = 0;
  vec_t        t1[5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int wl, input bit dec);
    laser_start = 0;
    laser_vld = 0;
    step();
    step();
    win_len = 8'(wl);
    decim = dec;
    laser_start = 1;
    w_m = (wl + 1 > 32) ? 32 : wl + 1;
    dec_m = dec;
    ph_m = 0;
    hist.delete();
  endtask

  task automatic model(input logic [63:0] d, output bit emit, output logic [63:0] avg);
    int s;
    hist.push_back(d);
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int i = 0; i < w_m && i < hist.size(); i++) s += int'(hist[hist.size() - 1 - i][c*16 +: 16]);
      avg[c*16 +: 16] = 16'(s / w_m);
    end
    emit = !dec_m || ph_m == w_m - 1;
    ph_m = (ph_m == w_m - 1) ? 0 : ph_m + 1;
  endtask

  task automatic sample(input logic [63:0] d, input int gap, input bit use_e = 0, input logic [63:0] e = '0);
    bit em;
    logic [63:0] a;
    laser_vld = 1;
    laser_data = d;
    model(d, em, a);
    if (em) sb.push_back('{due: cyc + 4, d: use_e ? e : a});
    step();
    laser_vld = 0;
    repeat (gap) step();
  endtask

  task automatic sample_raw(input logic [63:0] d);
    laser_vld = 1;
    laser_data = d;
    step();
    laser_vld = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL missing_strobe: got none required %h due cycle %0d", sb[0].d, sb[0].due);
      void'(sb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) last_d = '0;
    else if (lp_vld) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got %h required none (cycle %0d)", lp_data, cyc);
      end else begin
        x = sb.pop_front();
        chk("latency", 64'(cyc), 64'(x.due));
        chk("data", lp_data, x.d);
      end
      last_d = lp_data;
    end else chk("hold", lp_data, last_d);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1[0] = '{pk(4, 0, 0, 0),  pk(1, 0, 0, 0),  1'b0};
    t1[1] = '{pk(8, 0, 0, 0),  pk(3, 0, 0, 0),  1'b0};
    t1[2] = '{pk(12, 0, 0, 0), pk(6, 0, 0, 0),  1'b0};
    t1[3] = '{pk(16, 0, 0, 0), pk(10, 0, 0, 0), 1'b1};
    t1[4] = '{pk(20, 0, 0, 0), pk(14, 0, 0, 0), 1'b1};
    step();
    step();
    chk("rst_vld", 64'(lp_vld), 64'(0));
    chk("rst_data", lp_data, 64'(0));
    chk("rst_full", 64'(win_full), 64'(0));
    rst = 0;
    step();
    // W=4, no decimation, fixed table of expected outputs
    start_run(3, 0);
    foreach (t1[i]) begin
      sample(t1[i].d, 0, 1, t1[i].e);
      chk("win_full", 64'(win_full), 64'(t1[i].full));
    end
    drain();
    // W=4 decimated: two strobes over eight samples
    start_run(3, 1);
    for (int i = 0; i < 8; i++) sample(pk(100, 100, 100, 100), 0);
    drain();
    // clamp to MAX_TAPS with full-scale data
    start_run(255, 0);
    for (int i = 0; i < 40; i++) sample(pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0);
    drain();
    chk("clamp_full", 64'(win_full), 64'(1));
    // W=3, gapped valid, per-channel constants
    start_run(2, 0);
    for (int i = 0; i < 6; i++) sample(pk(7, 8, 9, 16'hFFFF), 2);
    drain();
    start_run(2, 0);
    sample(pk(1, 5, 0, 0), 2);
    sample(pk(1, 5, 0, 0), 2);
    sample(pk(0, 5, 0, 0), 2);
    drain();
    // start dropped with a sample still in the pipeline
    start_run(3, 0);
    for (int i = 0; i < 4; i++) sample(pk(40, 1, 2, 3), 0);
    drain();
    chk("drop_full_before", 64'(win_full), 64'(1));
    sample_raw(pk(50, 50, 50, 50));
    step();
    laser_start = 0;
    step();
    chk("drop_full_after", 64'(win_full), 64'(0));
    repeat (6) step();
    start_run(1, 0);
    sample(pk(10, 0, 0, 0), 0);
    sample(pk(20, 0, 0, 0), 0);
    win_len = 8'd0;
    sample(pk(30, 0, 0, 0), 0);
    drain();
    // asynchronous reset mid-stream, start held high across release
    start_run(2, 0);
    sample(pk(3, 3, 3, 3), 0);
    sample(pk(6, 6, 6, 6), 0);
    sample(pk(9, 9, 9, 9), 0);
    #2;
    rst = 1;
    sb.delete();
    #1;
    chk("arst_vld", 64'(lp_vld), 64'(0));
    chk("arst_data", lp_data, 64'(0));
    chk("arst_full", 64'(win_full), 64'(0));
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) sample_raw(pk(77, 77, 77, 77));
    repeat (8) step();
    chk("no_edge_full", 64'(win_full), 64'(0));
    start_run(1, 0);
    sample(pk(10, 0, 0, 0), 0);
    sample(pk(20, 0, 0, 0), 0);
    drain();
    laser_start = 0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
